// File: rtl/decoder3_8_seq.sv
// ---------------------------------------------------------------------------
// decoder3_8_seq
//
// Registered 3-to-8 one-hot decoder with valid/ready handshakes on both
// sides, plus a self-timed scan mode that walks a single 1 across out[0..7].
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        synchronous, active-high reset
//   en         global enable; gates new accepts and scan progress
//   in_valid   in carries a code
//   in_ready   block accepts in this cycle (combinational)
//   in         binary code 0..7
//   out_ready  downstream accepts out
//   out_valid  out holds a decoded code awaiting handshake
//   out        one-hot decoded value or scan pattern, otherwise 0
//   scan_start request a scan (only honoured in IDLE)
//   busy       high while scanning
//   scan_done  one-cycle pulse after the last scan position
//
// Parameters
//   DWELL  cycles each scan position is held (1..255)
//   CW     dwell counter width, 2**CW must exceed DWELL
// ---------------------------------------------------------------------------
module decoder3_8_seq #(
   parameter int unsigned DWELL = 2,
   parameter int unsigned CW    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out,
   input  logic       scan_start,
   output logic       busy,
   output logic       scan_done
);

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StScan
   } state_e;

   localparam logic [CW-1:0] DwellLast = CW'(DWELL - 1);

   state_e          state_q, state_d;
   logic [7:0]      out_q, out_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            accept;

   assign accept = in_valid & in_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         out_q   <= 8'h00;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // scan_start wins; in_ready is already low so the code stays pending
            if (scan_start && en) begin
               state_d = StScan;
               out_d   = 8'b0000_0001;
               cnt_d   = '0;
            end else if (accept) begin
               state_d = StHold;
               out_d   = 8'b0000_0001 << in;
            end
         end

         StHold: begin
            if (out_ready) begin
               if (accept) begin
                  // back-to-back: replace the handed-off code in the same cycle
                  out_d = 8'b0000_0001 << in;
               end else begin
                  state_d = StIdle;
                  out_d   = 8'h00;
               end
            end
         end

         StScan: begin
            if (en) begin
               if (cnt_q == DwellLast) begin
                  cnt_d = '0;
                  if (out_q[7]) begin
                     state_d = StIdle;
                     out_d   = 8'h00;
                     done_d  = 1'b1;
                  end else begin
                     out_d = out_q << 1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = StIdle;
            out_d   = 8'h00;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      out       = out_q;
      out_valid = (state_q == StHold);
      busy      = (state_q == StScan);
      scan_done = done_q;
      in_ready  = en & ~scan_start &
                  ((state_q == StIdle) | ((state_q == StHold) & out_ready));
   end

endmodule
